// File: rtl/edge_row_packer_pkg.sv
// Shared constants, FSM encoding and row-word layout for the edge-detection
// result path.
package edge_row_packer_pkg;

  localparam int IMG_DIM    = 20;
  localparam int BIT_LENGTH = 5;
  localparam int ROW_W      = 5;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef struct packed {
    logic [ROW_W-1:0]   row_idx;
    logic [IMG_DIM-1:0] row_data;
  } row_word_t;

endpackage

// File: rtl/edge_row_packer_row_fifo.sv
// Synchronous power-of-two FIFO for completed row words; a push into a full
// FIFO succeeds only when a pop frees the slot on the same edge.
module row_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage is not reset; an entry is only observable after a push.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/edge_row_packer.sv
// Packs the serial edge stream into row words, buffers them and presents
// them on a valid/ready port with row index, frame-done and overflow.
module edge_row_packer
  import edge_row_packer_pkg::*;
#(
  parameter int IMG_DIM    = edge_row_packer_pkg::IMG_DIM,
  parameter int FIFO_DEPTH = edge_row_packer_pkg::FIFO_DEPTH,
  parameter int ROW_W      = edge_row_packer_pkg::ROW_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               edge_in,
  input  logic               edge_valid,
  input  logic               frame_start,
  output logic [IMG_DIM-1:0] row_data,
  output logic [ROW_W-1:0]   row_idx,
  output logic               row_valid,
  input  logic               row_ready,
  output logic               frame_done,
  output logic               overflow
);

  localparam int CW = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_DIM - 1);

  state_e                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [IMG_DIM-1:0]       shift_q, shift_d;
  logic                     ovf_q, ovf_d;
  logic                     capture, push, pop, flush, full, empty;
  logic [IMG_DIM+ROW_W-1:0] fifo_din, fifo_dout;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    shift_d  = shift_q;
    ovf_d    = ovf_q;
    capture  = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    fifo_din = '0;

    if (frame_start) begin
      flush   = 1'b1;
      state_d = COLLECT;
      col_d   = '0;
      row_d   = '0;
      shift_d = '0;
      ovf_d   = 1'b0;
      capture = edge_valid;
    end else begin
      case (state_q)
        IDLE: begin
          if (edge_valid) begin
            state_d = COLLECT;
            capture = 1'b1;
          end
        end
        COLLECT: capture = edge_valid;
        DRAIN:   if (empty) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // col_d/row_d already reflect a same-cycle restart, so a bit sampled
    // with frame_start lands in column 0 of row 0.
    if (capture) begin
      shift_d[col_d] = edge_in;
      if (col_d == COL_LAST) begin
        push     = 1'b1;
        fifo_din = {row_d, shift_d};
        col_d    = '0;
        if (full && !pop) ovf_d = 1'b1;
        if (row_d == ROW_LAST) begin
          row_d   = '0;
          state_d = DRAIN;
        end else begin
          row_d = row_d + 1'b1;
        end
      end else begin
        col_d = col_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  row_fifo #(
    .WIDTH (IMG_DIM + ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign row_valid  = ~empty;
  assign pop        = row_valid & row_ready;
  assign row_data   = empty ? '0 : fifo_dout[IMG_DIM-1:0];
  assign row_idx    = empty ? '0 : fifo_dout[IMG_DIM+ROW_W-1:IMG_DIM];
  assign frame_done = (state_q == DONE);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_edge_row_packer.sv
// Directed bench for edge_row_packer: full frame, backpressure and drop,
// push/pop at full, gapped input, restart, and asynchronous reset.
module tb_edge_row_packer;

  logic        clk, reset, edge_in, edge_valid, frame_start, row_ready;
  logic [19:0] row_data;
  logic [4:0]  row_idx;
  logic        row_valid, frame_done, overflow;
  logic [19:0] pat;

  int checks = 0;
  int errors = 0;

  edge_row_packer dut (
    .clk         (clk),
    .reset       (reset),
    .edge_in     (edge_in),
    .edge_valid  (edge_valid),
    .frame_start (frame_start),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [4:0] idx, input logic [19:0] d);
    check({tag, "_valid"}, 32'(row_valid), 32'd1);
    check({tag, "_idx"},   32'(row_idx),   32'(idx));
    check({tag, "_data"},  32'(row_data),  32'(d));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 32'(row_valid),  32'd0);
    check({tag, "_data"},  32'(row_data),   32'd0);
    check({tag, "_idx"},   32'(row_idx),    32'd0);
    check({tag, "_done"},  32'(frame_done), 32'd0);
    check({tag, "_ovf"},   32'(overflow),   32'd0);
  endtask

  task automatic send_row(input logic [19:0] d, input logic rdy, input logic rdy_last);
    for (int c = 0; c < 20; c++) begin
      edge_valid = 1'b1;
      edge_in    = d[c];
      row_ready  = (c == 19) ? rdy_last : rdy;
      tick();
    end
    edge_valid = 1'b0;
    edge_in    = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    edge_valid  = 1'b0;
    row_ready   = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; edge_in = 1'b0; edge_valid = 1'b0;
    frame_start = 1'b0; row_ready = 1'b0;
    repeat (2) tick();
    check_zero("reset0");
    reset = 1'b0;
    tick();

    // Full frame from IDLE, consumer always ready.
    row_ready = 1'b1;
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 20; c++) begin
        edge_valid = 1'b1;
        edge_in    = (c % 2 == 0);
        tick();
        if (c == 0 && r > 0) check("full_popped", 32'(row_valid), 32'd0);
      end
      check_head("full_row", 5'(r), 20'h55555);
    end
    edge_valid = 1'b0;
    tick();
    check("full_done_early", 32'(frame_done), 32'd0);
    check("full_empty",      32'(row_valid),  32'd0);
    tick();
    check("full_done_pulse", 32'(frame_done), 32'd1);
    check("full_ovf",        32'(overflow),   32'd0);
    tick();
    check("full_done_end",   32'(frame_done), 32'd0);

    // Backpressure: row 2 dropped, later indices preserved.
    pulse_start();
    check("bp_start_empty", 32'(row_valid), 32'd0);
    send_row(20'h00001, 1'b0, 1'b0);
    send_row(20'h00002, 1'b0, 1'b0);
    check("bp_full_no_ovf", 32'(overflow), 32'd0);
    send_row(20'h00004, 1'b0, 1'b0);
    check("bp_ovf_set", 32'(overflow), 32'd1);
    check_head("bp_hold", 5'd0, 20'h00001);
    row_ready = 1'b1;
    tick();
    check_head("bp_r1", 5'd1, 20'h00002);
    tick();
    check("bp_drained", 32'(row_valid), 32'd0);
    send_row(20'h00008, 1'b0, 1'b0);
    check_head("bp_r3", 5'd3, 20'h00008);
    check("bp_ovf_sticky", 32'(overflow), 32'd1);
    row_ready = 1'b1;
    tick();
    check("bp_r3_popped", 32'(row_valid), 32'd0);

    // Push and pop on the same edge while full.
    pulse_start();
    check("pp_ovf_cleared", 32'(overflow), 32'd0);
    send_row(20'h00001, 1'b0, 1'b0);
    send_row(20'h00002, 1'b0, 1'b0);
    send_row(20'h00004, 1'b0, 1'b1);
    check("pp_no_ovf", 32'(overflow), 32'd0);
    check_head("pp_r1", 5'd1, 20'h00002);
    tick();
    check_head("pp_r2", 5'd2, 20'h00004);
    tick();
    check("pp_empty", 32'(row_valid), 32'd0);

    // Gapped input with garbage on edge_in during gaps.
    pulse_start();
    pat = 20'hABCDE;
    for (int c = 0; c < 20; c++) begin
      edge_valid = 1'b1; edge_in = pat[c]; tick();
      edge_valid = 1'b0; edge_in = ~pat[c]; tick();
    end
    repeat (3) tick();
    check_head("gap", 5'd0, 20'hABCDE);
    row_ready = 1'b1;
    tick();
    check("gap_single_row", 32'(row_valid), 32'd0);
    row_ready = 1'b0;

    // Restart mid-row with two rows buffered and overflow set.
    pulse_start();
    for (int r = 0; r < 5; r++) send_row(20'h0000F, 1'b0, 1'b0);
    check("rs_ovf_before", 32'(overflow),  32'd1);
    check("rs_buffered",   32'(row_valid), 32'd1);
    pat = 20'hFFFFF;
    for (int c = 0; c < 7; c++) begin
      edge_valid = 1'b1; edge_in = pat[c]; tick();
    end
    pat = 20'h12345;
    frame_start = 1'b1; edge_valid = 1'b1; edge_in = pat[0];
    tick();
    frame_start = 1'b0;
    check("rs_flushed",     32'(row_valid), 32'd0);
    check("rs_ovf_cleared", 32'(overflow),  32'd0);
    for (int c = 1; c < 20; c++) begin
      edge_valid = 1'b1; edge_in = pat[c]; tick();
    end
    edge_valid = 1'b0;
    check_head("rs_row0", 5'd0, 20'h12345);

    // Asynchronous reset mid-stream with data buffered and overflow set.
    send_row(20'h00001, 1'b0, 1'b0);
    send_row(20'h00002, 1'b0, 1'b0);
    check("ar_ovf_before", 32'(overflow), 32'd1);
    pat = 20'hFFFFF;
    for (int c = 0; c < 5; c++) begin
      edge_valid = 1'b1; edge_in = pat[c]; tick();
    end
    edge_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    check_zero("async_rst");
    tick();
    reset = 1'b0;
    tick();
    send_row(20'hF0F0F, 1'b0, 1'b0);
    check_head("post_rst", 5'd0, 20'hF0F0F);
    check("post_rst_ovf", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_row_packer.md
Name: edge_row_packer

Overview:
- Downstream consumer of the edge-detection core's serial result stream (one edge bit per cycle, qualified by the core's readable strobe).
- Packs raster-order bits into IMG_DIM-bit row words and buffers them in a small FIFO.
- Presents each row on a valid/ready handshake with its row index.
- Signals end of frame and any dropped rows.

Parameters:
- IMG_DIM, 20, image width and height in pixels; bits per row word and rows per frame.
- FIFO_DEPTH, 2, number of complete row words buffered; power of two, at least 2.
- ROW_W, 5, row index width; must be at least clog2(IMG_DIM).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- edge_in  input  1  edge bit from the core's edge_out.
- edge_valid  input  1  edge_in is valid this cycle; driven by the core's readable.
- frame_start  input  1  synchronous one-cycle pulse that starts a new frame.
- row_data  output  IMG_DIM  packed row at FIFO head; bit c is column c.
- row_idx  output  ROW_W  row number of row_data, 0..IMG_DIM-1.
- row_valid  output  1  FIFO head is valid.
- row_ready  input  1  consumer accepts the head word when row_valid=1.
- frame_done  output  1  one-cycle pulse when the whole frame has been delivered.
- overflow  output  1  sticky flag: at least one row was dropped this frame.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears the shift register, column and row counters, and FIFO pointers/count.
  - Outputs: row_data=0, row_idx=0, row_valid=0, frame_done=0, overflow=0.
  - State goes to IDLE.
- States:
  - IDLE: entered from reset or after DONE. Goes to COLLECT on frame_start, or on the first edge_valid=1; that first bit is captured.
  - COLLECT: captures bits. When the last bit of row IMG_DIM-1 is captured, goes to DRAIN.
  - DRAIN: ignores edge_valid (stray bits dropped, no overflow). Goes to DONE when the FIFO is empty.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- Capture:
  - Each cycle in COLLECT with edge_valid=1 writes edge_in into the row shift register at bit position col.
  - col increments and wraps 0..IMG_DIM-1.
  - Cycles with edge_valid=0 leave all state unchanged; gaps are allowed anywhere.
- Row completion, when col=IMG_DIM-1 with edge_valid=1:
  - The full word, including the current bit, plus the current row number are pushed into the FIFO on that clock edge.
  - col goes to 0 and row increments.
  - row_valid is visible the next cycle (1-cycle latency from the last bit to an empty FIFO's output).
- FIFO:
  - Pop occurs when row_valid & row_ready.
  - row_data and row_idx are driven from the head entry and are stable while row_valid=1 and row_ready=0.
  - Push and pop in the same cycle are both performed; when full, the pop frees the slot and the push succeeds.
  - Push when full with no pop drops the row and sets overflow=1. The row counter still advances, so later rows keep their correct indices.
  - overflow stays 1 until reset or frame_start.
- frame_start, in any state:
  - Discards the partial row and all FIFO contents.
  - Zeroes col and row, clears overflow, sets row_valid=0 next cycle.
  - Goes to COLLECT.
  - If frame_start and edge_valid occur in the same cycle, that bit is captured as column 0 of row 0.
- frame_done:
  - Asserts in DONE only, i.e. the cycle after the FIFO becomes empty once all rows have been produced.
  - A consumer that never asserts row_ready holds the block in DRAIN indefinitely.
- Widths: col is clog2(IMG_DIM) bits; row is ROW_W bits. Neither counter exceeds IMG_DIM-1.

Decomposition:
- Shared package holds:
  - IMG_DIM and the BIT_LENGTH constant (5) used by the core.
  - The state encoding localparams (IDLE/COLLECT/DRAIN/DONE).
  - The row-word struct/typedef {row_idx, row_data}.
- One sub-module: row_fifo. It is a synchronous FIFO with parameters WIDTH=IMG_DIM+ROW_W and DEPTH=FIFO_DEPTH, and ports push, pop, full, empty, din, dout.
- The FSM, counters and shift register stay in edge_row_packer.

Test Plan:
- Reset: assert reset mid-stream -> all outputs 0 immediately (asynchronous), FIFO empty, state IDLE.
- Full frame, row_ready=1, 400 contiguous valid bits, bit = 1 for even columns -> 20 rows, each row_data=20'h55555, row_idx 0..19 in order. Each row_valid appears 1 cycle after its 20th bit. frame_done pulses once, 1 cycle after the row-19 handshake. overflow=0.
- Backpressure: row_ready=0 while rows 0,1,2 complete -> rows 0 and 1 held, row 2 dropped, overflow=1. Then raise row_ready -> rows come out with row_idx 0, 1, then 3. overflow stays 1 to the end of the frame.
- Push/pop when full: FIFO full, row_ready=1 in the exact cycle row 2 completes -> row 0 popped, row 2 stored, overflow=0.
- Gapped input: edge_valid toggles 1/0 across a row with pattern 20'hABCDE -> row_data=20'hABCDE. Cycles with edge_valid=0 have no effect.
- Restart: frame_start during column 7 of row 5 with 2 rows buffered -> row_valid=0 the next cycle, overflow cleared. The next completed row reports row_idx=0, and its column 0 bit is the one sampled with frame_start if edge_valid was high.
